// File: rtl/arm_alu_pkg.sv
// Opcode encodings, FSM states and flag bit positions for the ARM ALU.
package arm_alu_pkg;

  localparam int unsigned OP_W    = 5;
  localparam int unsigned FLAGS_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam logic [OP_W-1:0] OP_AND    = 5'h00;
  localparam logic [OP_W-1:0] OP_EOR    = 5'h01;
  localparam logic [OP_W-1:0] OP_SUB    = 5'h02;
  localparam logic [OP_W-1:0] OP_RSB    = 5'h03;
  localparam logic [OP_W-1:0] OP_ADD    = 5'h04;
  localparam logic [OP_W-1:0] OP_ADC    = 5'h05;
  localparam logic [OP_W-1:0] OP_SBC    = 5'h06;
  localparam logic [OP_W-1:0] OP_RSC    = 5'h07;
  localparam logic [OP_W-1:0] OP_TST    = 5'h08;
  localparam logic [OP_W-1:0] OP_TEQ    = 5'h09;
  localparam logic [OP_W-1:0] OP_CMP    = 5'h0A;
  localparam logic [OP_W-1:0] OP_CMN    = 5'h0B;
  localparam logic [OP_W-1:0] OP_ORR    = 5'h0C;
  localparam logic [OP_W-1:0] OP_BIC    = 5'h0E;
  localparam logic [OP_W-1:0] OP_MVN    = 5'h0F;
  localparam logic [OP_W-1:0] OP_BYPASS = 5'h10;
  localparam logic [OP_W-1:0] OP_INC    = 5'h11;
  localparam logic [OP_W-1:0] OP_MUL    = 5'h12;
  localparam logic [OP_W-1:0] OP_MLA    = 5'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

  // True for opcodes handled by the multi-cycle multiplier
  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MLA);
  endfunction

endpackage

// File: rtl/arm_mul_shiftadd.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
// The first bit is consumed on the start edge so busy drops after WIDTH edges.
module arm_mul_shiftadd #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Load on start (bit 0 folded in), then accumulate one shifted partial product per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
      cnt    <= CNT_W'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/arm_alu_seq.sv
// Registered ARM data-processing ALU with start/done handshake and multi-cycle MUL/MLA.
module arm_alu_seq
  import arm_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [OP_W-1:0]    op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [FLAGS_W-1:0] flags_in,
  input  logic               s,
  output logic               ready,
  output logic               done,
  output logic               wr_en,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags_out
);

  state_t state;

  // Values latched at accept for the multi-cycle path
  logic             mla_q;
  logic [WIDTH-1:0] c_q;
  logic [1:0]       cv_q;
  logic             s_q;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             add_c;
  logic             add_v;

  logic [WIDTH-1:0]   alu_res;
  logic [FLAGS_W-1:0] alu_flags;
  logic               alu_arith;
  logic               alu_known;
  logic               alu_wr;

  logic             mul_start;
  logic             mul_busy;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] mul_final;

  // Adder operand selection: subtracts use inverted operand, carry-in is 1 or C
  always_comb begin
    add_x  = '0;
    add_y  = '0;
    add_ci = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin add_x = a; add_y = ~b; add_ci = 1'b1; end
      OP_RSB:         begin add_x = b; add_y = ~a; add_ci = 1'b1; end
      OP_ADD, OP_CMN: begin add_x = a; add_y = b;  add_ci = 1'b0; end
      OP_ADC:         begin add_x = a; add_y = b;  add_ci = flags_in[FLAG_C]; end
      OP_SBC:         begin add_x = a; add_y = ~b; add_ci = flags_in[FLAG_C]; end
      OP_RSC:         begin add_x = b; add_y = ~a; add_ci = flags_in[FLAG_C]; end
      OP_INC:         begin add_x = a; add_y = '0; add_ci = 1'b1; end
      default:        begin add_x = '0; add_y = '0; add_ci = 1'b0; end
    endcase
  end

  assign sum_ext = {1'b0, add_x} + {1'b0, add_y} + (WIDTH + 1)'(add_ci);
  assign sum     = sum_ext[WIDTH-1:0];
  assign add_c   = sum_ext[WIDTH];
  assign add_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  // Single-cycle result, flags and write-enable decode
  always_comb begin
    alu_res   = '0;
    alu_arith = 1'b0;
    alu_known = 1'b1;
    alu_wr    = 1'b1;
    case (op)
      OP_AND:    alu_res = a & b;
      OP_EOR:    alu_res = a ^ b;
      OP_TST:    begin alu_res = a & b; alu_wr = 1'b0; end
      OP_TEQ:    begin alu_res = a ^ b; alu_wr = 1'b0; end
      OP_ORR:    alu_res = a | b;
      OP_BIC:    alu_res = a & ~b;
      OP_MVN:    alu_res = ~b;
      OP_BYPASS: alu_res = b;
      OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC: begin
        alu_res   = sum;
        alu_arith = 1'b1;
      end
      OP_CMP, OP_CMN: begin
        alu_res   = sum;
        alu_arith = 1'b1;
        alu_wr    = 1'b0;
      end
      OP_INC:    alu_res = sum;
      default: begin
        alu_known = 1'b0;
        alu_wr    = 1'b0;
      end
    endcase
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_arith ? add_c : flags_in[FLAG_C];
    alu_flags[FLAG_V] = alu_arith ? add_v : flags_in[FLAG_V];
  end

  assign mul_start = (state == ST_IDLE) && start && is_mul_op(op);
  assign mul_final = mul_product + (mla_q ? c_q : '0);

  arm_mul_shiftadd #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .product (mul_product)
  );

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      result    <= '0;
      flags_out <= '0;
      mla_q     <= 1'b0;
      c_q       <= '0;
      cv_q      <= '0;
      s_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          if (start) begin
            ready <= 1'b0;
            mla_q <= (op == OP_MLA);
            c_q   <= c;
            cv_q  <= {flags_in[FLAG_C], flags_in[FLAG_V]};
            s_q   <= s;
            if (is_mul_op(op)) begin
              state <= ST_MUL;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
              wr_en <= alu_wr;
              if (alu_wr) begin
                result <= alu_res;
              end
              if (s && alu_known) begin
                flags_out <= alu_flags;
              end
            end
          end
        end
        ST_MUL: begin
          if (!mul_busy) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            wr_en  <= 1'b1;
            result <= mul_final;
            if (s_q) begin
              flags_out <= {mul_final[WIDTH-1], (mul_final == '0), cv_q};
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          wr_en <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          wr_en <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_alu_seq.sv
// Directed-vector bench for arm_alu_seq with hand-computed expectations.
module tb_arm_alu_seq;
  import arm_alu_pkg::*;

  localparam int unsigned WIDTH = 32;

  logic               clk;
  logic               reset;
  logic               start;
  logic [OP_W-1:0]    op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [FLAGS_W-1:0] flags_in;
  logic               s;
  logic               ready;
  logic               done;
  logic               wr_en;
  logic [WIDTH-1:0]   result;
  logic [FLAGS_W-1:0] flags_out;

  int passed = 0;
  int total  = 0;
  int done_seen;

  arm_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .flags_in  (flags_in),
    .s         (s),
    .ready     (ready),
    .done      (done),
    .wr_en     (wr_en),
    .result    (result),
    .flags_out (flags_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Present one op for one cycle; returns at the negedge one cycle after start
  task automatic start_op(input logic [OP_W-1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [3:0] f, input logic sv);
    @(negedge clk);
    op = o; a = x; b = y; c = z; flags_in = f; s = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Single-cycle op: check the DONE cycle contents
  task automatic single(input string tag, input logic [OP_W-1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [3:0] f, input logic sv,
                        input logic exp_wr, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    start_op(o, x, y, 32'h0, f, sv);
    check({tag, ".done"}, 32'(done), 32'h1);
    check({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, 32'(flags_out), 32'(exp_fl));
    @(negedge clk);
    check({tag, ".done_drop"}, 32'(done), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; c = '0; flags_in = '0; s = 1'b0;
    #1;
    check("rst.ready", 32'(ready), 32'h1);
    check("rst.done", 32'(done), 32'h0);
    check("rst.wr_en", 32'(wr_en), 32'h0);
    check("rst.result", result, 32'h0);
    check("rst.flags", 32'(flags_out), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // SUB: ready must be low during DONE, back high after
    start_op(OP_SUB, 32'd5, 32'd7, 32'h0, 4'b0000, 1'b1);
    check("sub.ready_low", 32'(ready), 32'h0);
    check("sub.done", 32'(done), 32'h1);
    check("sub.result", result, 32'hFFFFFFFE);
    check("sub.flags", 32'(flags_out), 32'h8);
    @(negedge clk);
    check("sub.ready_back", 32'(ready), 32'h1);
    check("sub.done_drop", 32'(done), 32'h0);

    single("add_ovf",  OP_ADD, 32'h7FFFFFFF, 32'h1, 4'b0000, 1'b1, 1'b1, 32'h80000000, 4'b1001);
    single("add_wrap", OP_ADD, 32'hFFFFFFFF, 32'h1, 4'b0000, 1'b1, 1'b1, 32'h0, 4'b0110);
    single("add_1234", OP_ADD, 32'h1230, 32'h4, 4'b0110, 1'b1, 1'b1, 32'h1234, 4'b0000);
    single("cmp_s1",   OP_CMP, 32'd3, 32'd3, 4'b0000, 1'b1, 1'b0, 32'h1234, 4'b0110);
    single("cmp_s0",   OP_CMP, 32'd3, 32'd3, 4'b0000, 1'b0, 1'b0, 32'h1234, 4'b0110);
    single("eor",      OP_EOR, 32'hF0F0, 32'hF0F0, 4'b0011, 1'b1, 1'b1, 32'h0, 4'b0111);
    single("rsb",      OP_RSB, 32'd7, 32'd5, 4'b0000, 1'b1, 1'b1, 32'hFFFFFFFE, 4'b1000);
    single("inc",      OP_INC, 32'hFFFFFFFF, 32'h0, 4'b0011, 1'b1, 1'b1, 32'h0, 4'b0111);
    single("adc",      OP_ADC, 32'd1, 32'd1, 4'b0010, 1'b1, 1'b1, 32'h3, 4'b0000);
    single("undef",    5'h0D, 32'd5, 32'd5, 4'b1111, 1'b1, 1'b0, 32'h3, 4'b0000);

    // MUL with an ignored start pulse while busy
    start_op(OP_MUL, 32'h10000, 32'h10000, 32'h0, 4'b0011, 1'b1);
    check("mul.done_p1", 32'(done), 32'h0);
    check("mul.ready_low", 32'(ready), 32'h0);
    for (int k = 2; k <= 33; k++) begin
      @(negedge clk);
      if (k == 4) begin
        op = OP_ADD; a = 32'd1; b = 32'd1; flags_in = 4'b0000; s = 1'b1; start = 1'b1;
      end
      if (k == 5) start = 1'b0;
      if (k == 6) check("mul.ignored_start", 32'(done), 32'h0);
      if (k == 32) begin
        check("mul.done_p32", 32'(done), 32'h0);
        check("mul.result_hold", result, 32'h3);
      end
    end
    check("mul.done_p33", 32'(done), 32'h1);
    check("mul.wr_en", 32'(wr_en), 32'h1);
    check("mul.result", result, 32'h0);
    check("mul.flags", 32'(flags_out), 32'h7);
    @(negedge clk);
    check("mul.done_drop", 32'(done), 32'h0);

    // MLA 3*4+5, flags not updated
    start_op(OP_MLA, 32'd3, 32'd4, 32'd5, 4'b0000, 1'b0);
    repeat (32) @(negedge clk);
    check("mla.done", 32'(done), 32'h1);
    check("mla.result", result, 32'h11);
    check("mla.flags", 32'(flags_out), 32'h7);

    // MUL aborted by asynchronous reset mid-operation
    start_op(OP_MUL, 32'd7, 32'd9, 32'h0, 4'b0000, 1'b1);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort.ready", 32'(ready), 32'h1);
    check("abort.done", 32'(done), 32'h0);
    check("abort.wr_en", 32'(wr_en), 32'h0);
    check("abort.result", result, 32'h0);
    check("abort.flags", 32'(flags_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort.no_done", 32'(done_seen), 32'h0);
    check("abort.ready_idle", 32'(ready), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
